// File: rtl/msg_detector_scheduler.sv
// Round-robin scheduler sharing one serial 4-ones detector among N requesters.
// Grants a word, clears the detector, shifts the word MSB first, reports hits.
module msg_detector_scheduler #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int HW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       words,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 det_reset,
  output logic                 det_bit,
  input  logic                 det_hit,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [$clog2(N)-1:0] res_id,
  output logic [HW-1:0]        res_hits
);

  localparam int IW = $clog2(N);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt_ptr;
  logic          found;
  logic [W-1:0]  sel_word;
  logic [W-1:0]  shreg;
  logic [CW-1:0] bit_cnt;
  int            j;

  // Scan ptr, ptr+1, ... mod N for the first asserted request
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    idx      = '0;
    j        = 0;
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == sel) sel_word = words[i*W +: W];
    end
  end

  assign nxt_ptr = (sel == IW'(N-1)) ? '0 : sel + 1'b1;

  always_comb begin
    gnt = '0;
    if (state == IDLE && found && !reset) gnt[sel] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign det_reset = reset | (state == CLEAR);
  assign det_bit   = (state == SHIFT) & shreg[W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      res_id   <= '0;
      res_hits <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            shreg    <= sel_word;
            res_id   <= sel;
            res_hits <= '0;
            ptr      <= nxt_ptr;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          if (bit_cnt == CW'(W-1)) state <= DRAIN;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        DRAIN: state <= DONE;
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      // DRAIN still counts: the last bit's hit shows up one edge late
      if ((state == SHIFT || state == DRAIN) &&
          det_hit && res_hits != '1)
        res_hits <= res_hits + 1'b1;
    end
  end

endmodule

// File: tb/tb_msg_detector_scheduler.sv
// Bench for msg_detector_scheduler with behavioural 4-ones detectors.
// Expected id/hits come from a queue filled at grant time.
module tb_msg_detector_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  req;
  logic [31:0] words;
  logic [3:0]  gnt;
  logic        busy, det_reset, det_bit, det_hit;
  logic        res_valid, res_ready;
  logic [1:0]  res_id;
  logic [3:0]  res_hits;

  msg_detector_scheduler #(.N(4), .W(8), .HW(4)) dut_a (
    .clk(clk), .reset(reset), .req(req), .words(words),
    .gnt(gnt), .busy(busy), .det_reset(det_reset),
    .det_bit(det_bit), .det_hit(det_hit),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_hits(res_hits)
  );

  logic [1:0]  req_b;
  logic [31:0] words_b;
  logic [1:0]  gnt_b;
  logic        busy_b, det_reset_b, det_bit_b, det_hit_b;
  logic        res_valid_b, res_ready_b;
  logic [0:0]  res_id_b;
  logic [3:0]  res_hits_b;

  msg_detector_scheduler #(.N(2), .W(16), .HW(4)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .words(words_b),
    .gnt(gnt_b), .busy(busy_b), .det_reset(det_reset_b),
    .det_bit(det_bit_b), .det_hit(det_hit_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_id(res_id_b), .res_hits(res_hits_b)
  );

  // Moore detector: hit one edge after the 4th one, then back to idle
  logic [2:0] dc_a, dc_b;
  always @(posedge clk) begin
    if (det_reset) dc_a <= 3'd0;
    else if (dc_a == 3'd4) dc_a <= 3'd0;
    else if (det_bit) dc_a <= dc_a + 3'd1;
    else dc_a <= 3'd0;
  end
  always @(posedge clk) begin
    if (det_reset_b) dc_b <= 3'd0;
    else if (dc_b == 3'd4) dc_b <= 3'd0;
    else if (det_bit_b) dc_b <= dc_b + 3'd1;
    else dc_b <= 3'd0;
  end
  assign det_hit   = (dc_a == 3'd4);
  assign det_hit_b = (dc_b == 3'd4);

  typedef struct {
    int id;
    int hits;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic int model_hits(input logic [31:0] w,
                                    input int width, input int hw);
    int c = 0;
    int h = 0;
    for (int i = width - 1; i >= 0; i--) begin
      if (c == 4) c = 0;
      else if (w[i]) c++;
      else c = 0;
      if (c == 4 && h < (1 << hw) - 1) h++;
    end
    return h;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] exp_g,
                              output int waited);
    int k = 0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt === 4'b0 && waited < 40);
    check(tag, {28'b0, gnt}, {28'b0, exp_g});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) if (exp_g[i]) k = i;
    sb.push_back('{k, model_hits({24'b0, words[k*8 +: 8]}, 8, 4)});
  endtask

  task automatic expect_result(input string tag, input bit chk_lat);
    int cyc = 0;
    int nrst = 0;
    bit gnt_bad = 0;
    bit busy_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (res_valid !== 1'b1) begin
        nrst += int'(det_reset);
        if (gnt !== 4'b0) gnt_bad = 1;
        if (busy !== 1'b1) busy_bad = 1;
      end
    end while (res_valid !== 1'b1 && cyc < 60);
    check({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
    if (chk_lat) check({tag, "_lat"}, cyc, 32'd11);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      last_exp = sb.pop_front();
      check({tag, "_id"}, {30'b0, res_id}, last_exp.id);
      check({tag, "_hits"}, {28'b0, res_hits}, last_exp.hits);
    end
    check({tag, "_detrst"}, nrst, 32'd1);
    check({tag, "_gntq"}, {31'b0, gnt_bad}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy_bad}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    bit bp_bad;

    reset = 1'b1;
    req = '0;
    words = '0;
    res_ready = 1'b0;
    req_b = '0;
    words_b = '0;
    res_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_detbit", {31'b0, det_bit}, 32'd0);
    check("rst_detrst", {31'b0, det_reset}, 32'd1);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_id", {30'b0, res_id}, 32'd0);
    check("rst_hits", {28'b0, res_hits}, 32'd0);
    step();
    reset = 1'b0;

    // W=16 instance: all-ones word
    req_b = 2'b01;
    words_b = {16'h0000, 16'hFFFF};
    res_ready_b = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_b === 2'b0 && n < 40);
    check("w16_gnt", {30'b0, gnt_b}, 32'd1);
    step();
    req_b = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (res_valid_b !== 1'b1 && n < 60);
    check("w16_lat", n, 32'd19);
    check("w16_id", {31'b0, res_id_b}, 32'd0);
    check("w16_hits", {28'b0, res_hits_b},
          model_hits(32'h0000FFFF, 16, 4));
    step();

    // single words on requester 0 and 2
    words = {8'h00, 8'h00, 8'h00, 8'h78};
    req = 4'b0001;
    expect_grant("t1_gnt", 4'b0001, w);
    step();
    req = 4'b0000;
    expect_result("t1", 1'b1);
    accept();

    words = {8'h00, 8'hFF, 8'h00, 8'hEE};
    req = 4'b0001;
    expect_grant("t2_gnt", 4'b0001, w);
    step();
    req = 4'b0100;
    expect_result("t2", 1'b1);
    accept();
    expect_grant("t3_gnt", 4'b0100, w);
    step();
    req = 4'b0000;
    expect_result("t3", 1'b1);
    accept();

    // round robin from a fresh pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    words = {8'hF0, 8'hFF, 8'h0F, 8'h33};
    req = 4'b1010;
    res_ready = 1'b1;
    expect_grant("rr_g1", 4'b0010, w);
    expect_result("rr_r1", 1'b1);
    expect_grant("rr_g3", 4'b1000, w);
    expect_result("rr_r3", 1'b1);
    expect_grant("rr_g1b", 4'b0010, w);
    step();
    req = 4'b0011;
    expect_result("rr_r1b", 1'b1);
    expect_grant("rr_g0", 4'b0001, w);
    expect_result("rr_r0", 1'b1);
    expect_grant("rr_g1c", 4'b0010, w);
    step();
    req = 4'b0000;
    expect_result("rr_r1c", 1'b1);
    step();
    res_ready = 1'b0;

    // back-pressure with a pending request
    req = 4'b0100;
    expect_grant("bp_g2", 4'b0100, w);
    expect_result("bp_r2", 1'b1);
    bp_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || gnt !== 4'b0 ||
          res_id !== 2'(last_exp.id) ||
          res_hits !== 4'(last_exp.hits))
        bp_bad = 1;
    end
    check("bp_stable", {31'b0, bp_bad}, 32'd0);
    step();
    res_ready = 1'b1;
    expect_grant("bp_regnt", 4'b0100, w);
    check("bp_wait", w, 32'd2);
    step();
    req = 4'b0000;
    expect_result("bp_r2b", 1'b1);
    step();
    res_ready = 1'b0;

    // reset during SHIFT bit 3
    req = 4'b0001;
    expect_grant("mr_g0", 4'b0001, w);
    step();
    req = 4'b0000;
    repeat (4) step();
    check("mr_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mr_detrst", {31'b0, det_reset}, 32'd1);
    step();
    reset = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_valid", {31'b0, res_valid}, 32'd0);
    check("mr_hits", {28'b0, res_hits}, 32'd0);
    check("mr_gnt", {28'b0, gnt}, 32'd1);
    sb.push_back('{0, model_hits({24'b0, words[7:0]}, 8, 4)});
    step();
    req = 4'b0000;
    expect_result("mr_r0", 1'b1);
    accept();

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
